// File: rtl/button_gesture_pkg.sv
// Shared types and default timing constants for the button gesture classifier.
//   state_e          : gesture state machine encoding
//   DEF_*            : default counter width and tick thresholds
package button_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    HELD
  } state_e;

  localparam int unsigned DEF_CNT_W        = 16;
  localparam int unsigned DEF_LONG_TICKS   = 500;
  localparam int unsigned DEF_DCLICK_TICKS = 250;
  localparam int unsigned DEF_REPEAT_TICKS = 100;

endpackage

// File: rtl/button_gesture_timer.sv
// gesture_timer: saturating tick counter with synchronous clear and a
// threshold-compare strobe.
//   clk_i    : system clock
//   rst_i    : synchronous active-high reset (count -> 0)
//   clr_i    : clear count; overrides a coincident tick
//   tick_i   : timebase strobe, advances the count by one
//   thresh_i : threshold in ticks (>= 1)
//   hit_o    : tick_i high while count == thresh_i-1 (threshold reached now)
module gesture_timer
  import button_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] thresh_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = tick_i && (cnt_q == (thresh_i - CNT_W'(1)));

endmodule

// File: rtl/button_gesture.sv
// button_gesture: classifies a debounced button level into one-cycle gesture
// pulses (short press, long press, double click), timed in ticks of an
// external timebase strobe.
//   clk_i    : system clock
//   rst_i    : synchronous active-high reset
//   tick_i   : timebase strobe, one clk_i cycle wide
//   level_i  : debounced button level, 1 = pressed
//   short_o  : pulse, short press classified
//   long_o   : pulse, long-press threshold reached
//   double_o : pulse, double click classified
//   repeat_o : pulse, auto-repeat while held (0 unless BUTTON_GESTURE_REPEAT_EN)
//   busy_o   : state machine not in IDLE
// Optional feature macro: BUTTON_GESTURE_REPEAT_EN enables auto-repeat in HELD.
module button_gesture
  import button_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
  parameter int unsigned DCLICK_TICKS = DEF_DCLICK_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic level_i,
  output logic short_o,
  output logic long_o,
  output logic double_o,
  output logic repeat_o,
  output logic busy_o
);

  if (LONG_TICKS < 1 || 64'(LONG_TICKS) >= (64'd1 << CNT_W)) begin : g_bad_long
    $error("button_gesture: LONG_TICKS out of range");
  end
  if (DCLICK_TICKS < 1 || 64'(DCLICK_TICKS) >= (64'd1 << CNT_W)) begin : g_bad_dclick
    $error("button_gesture: DCLICK_TICKS out of range");
  end
  if (REPEAT_TICKS < 1 || 64'(REPEAT_TICKS) >= (64'd1 << CNT_W)) begin : g_bad_repeat
    $error("button_gesture: REPEAT_TICKS out of range");
  end

  localparam logic [CNT_W-1:0] LONG_W   = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] DCLICK_W = CNT_W'(DCLICK_TICKS);

  state_e state_q, state_d;
  logic   level_q;
  logic   short_q, short_d;
  logic   long_q, long_d;
  logic   double_q, double_d;
  logic   busy_q;
  logic   rise, fall;
  logic   hit;
  logic   cnt_clr;
  logic [CNT_W-1:0] thresh;

  assign rise = level_i & ~level_q;
  assign fall = ~level_i & level_q;

  // One counter serves both timed states; only the active state's threshold matters.
  assign thresh  = (state_q == WAIT2) ? DCLICK_W : LONG_W;
  // Clearing on any transition also discards a coincident tick.
  assign cnt_clr = (state_d != state_q);

  gesture_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (cnt_clr),
    .tick_i  (tick_i),
    .thresh_i(thresh),
    .hit_o   (hit)
  );

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          state_d = WAIT2;
        end else if (hit) begin
          long_d  = 1'b1;
          state_d = HELD;
        end
      end
      WAIT2: begin
        if (rise) begin
          state_d = PRESS2;
        end else if (hit) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      PRESS2: begin
        if (fall) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end
      end
      HELD: begin
        if (fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      level_q  <= 1'b1;  // a button held through reset must not count as a press
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_i;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign short_o  = short_q;
  assign long_o   = long_q;
  assign double_o = double_q;
  assign busy_o   = busy_q;

`ifdef BUTTON_GESTURE_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_W = CNT_W'(REPEAT_TICKS);

  logic rhit;
  logic rep_clr;
  logic repeat_q, repeat_d;

  // Held at zero outside HELD so it starts fresh on entry; wraps after each repeat.
  assign rep_clr = (state_q != HELD) | rhit;

  gesture_timer #(
    .CNT_W(CNT_W)
  ) u_rep_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (rep_clr),
    .tick_i  (tick_i),
    .thresh_i(REPEAT_W),
    .hit_o   (rhit)
  );

  always_comb begin
    repeat_d = 1'b0;
    if ((state_q == HELD) && !fall && rhit) repeat_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= repeat_d;
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule
